// File: rtl/sseg_capture.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment bus: synchronizes
// the active-low pins, waits for each dwell to settle, decodes glyphs and reports frames.
module sseg_capture #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] anode,
    input  logic [7:0] cathodes,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp,
    output logic [3:0] seg_err,
    output logic       frame_valid,
    output logic       anode_err
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLING, HELD} state_t;

    logic [3:0]    a_m, a_s;
    logic [7:0]    c_m, c_s;
    logic [CW-1:0] cnt;
    state_t        state;
    logic [3:0]    mask;
    logic [3:0]    dig [4];

    logic       changed, capture, one_hot, multi_low, hit;
    logic [3:0] sel, nib, new_mask;

    // a_s is about to take the first-stage value, so comparing the two stages
    // flags the edge on which the synchronized pattern changes.
    assign changed   = {a_m, c_m} != {a_s, c_s};
    assign capture   = (state == SETTLING) && !changed && (cnt == CNT_LAST);
    assign sel       = ~a_s;
    assign one_hot   = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign multi_low = (sel != 4'd0) && !one_hot;
    assign new_mask  = mask | sel;

    always_comb begin
        hit = 1'b1;
        nib = 4'd0;
        case (~c_s[6:0])
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_m         <= 4'hF;
            a_s         <= 4'hF;
            c_m         <= 8'hFF;
            c_s         <= 8'hFF;
            cnt         <= '0;
            state       <= IDLE;
            mask        <= 4'd0;
            dp          <= 4'd0;
            seg_err     <= 4'd0;
            frame_valid <= 1'b0;
            anode_err   <= 1'b0;
            for (int n = 0; n < 4; n++) dig[n] <= 4'd0;
        end else begin
            a_m         <= anode;
            a_s         <= a_m;
            c_m         <= cathodes;
            c_s         <= c_m;
            frame_valid <= 1'b0;
            anode_err   <= 1'b0;

            if (changed)             cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

            case (state)
                IDLE:     if (changed) state <= SETTLING;
                SETTLING: if (capture) state <= (one_hot) ? HELD : IDLE;
                HELD:     if (changed) state <= SETTLING;
                default:  state <= IDLE;
            endcase

            if (capture && multi_low) anode_err <= 1'b1;

            if (capture && one_hot) begin
                for (int n = 0; n < 4; n++) begin
                    if (sel[n]) begin
                        if (hit) dig[n] <= nib;
                        seg_err[n] <= !hit;
                        dp[n]      <= ~c_s[7];
                    end
                end
                if (new_mask == 4'hF) begin
                    mask        <= 4'd0;
                    frame_valid <= 1'b1;
                end else begin
                    mask <= new_mask;
                end
            end
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign digit3 = dig[3];
endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: dwell table with hand expectations, a reset sequence,
// and random dwells, all checked each cycle against a sliding-window reference model.
module tb_sseg_capture;
    localparam int S = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] anode = 4'hF;
    logic [7:0] cathodes = 8'hFF;
    logic [3:0] digit0, digit1, digit2, digit3, dp, seg_err;
    logic       frame_valid, anode_err;

    sseg_capture #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .anode(anode), .cathodes(cathodes),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dp(dp), .seg_err(seg_err), .frame_valid(frame_valid), .anode_err(anode_err)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  ca;
        int          cyc;
        logic [15:0] dig;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dpx;
        logic [3:0]  se;
        int          fv;
        int          ae;
    } vec_t;

    vec_t tab [$];
    int vecs = 0, errs = 0;
    int fvc, aec;

    // Reference model: a capture happens exactly when the synchronized pattern
    // has been constant for S+1 samples and the sample before that differed.
    logic [11:0] h [$];
    logic [3:0]  e_dig [4];
    logic [3:0]  e_dp, e_se, e_mask;
    logic        e_fv, e_ae;

    function automatic logic [7:0] cath(int nib, bit lit_dp);
        logic [6:0] g;
        g = glyph[nib];
        return {~lit_dp, ~g};
    endfunction

    function automatic logic [11:0] get(int i);
        return (i < h.size()) ? h[i] : 12'hFFF;
    endfunction

    task automatic model_step(input bit in_rst);
        logic [11:0] v;
        logic [3:0]  a;
        logic [6:0]  lit;
        bit          stable;
        int          lows, n, found;
        e_fv = 1'b0;
        e_ae = 1'b0;
        if (in_rst) begin
            h.delete();
            for (int k = 0; k < 4; k++) e_dig[k] = 4'd0;
            e_dp = 4'd0; e_se = 4'd0; e_mask = 4'd0;
            return;
        end
        h.push_front({anode, cathodes});
        if (h.size() > S + 3) void'(h.pop_back());
        stable = 1'b1;
        for (int j = 2; j <= S + 1; j++) if (get(j) != get(1)) stable = 1'b0;
        if (!stable || get(S + 2) == get(1)) return;
        v = get(1);
        a = v[11:8];
        lows = 0;
        n = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) begin lows++; n = k; end
        if (lows >= 2) e_ae = 1'b1;
        else if (lows == 1) begin
            lit = ~v[6:0];
            found = -1;
            for (int g = 0; g < 16; g++) if (glyph[g] == lit) found = g;
            if (found >= 0) begin
                e_dig[n] = 4'(found);
                e_se[n] = 1'b0;
            end else e_se[n] = 1'b1;
            e_dp[n] = ~v[7];
            e_mask[n] = 1'b1;
            if (e_mask == 4'hF) begin
                e_fv = 1'b1;
                e_mask = 4'd0;
            end
        end
    endtask

    task automatic cycle(input bit in_rst);
        logic [25:0] act, exp;
        @(posedge clk);
        #1;
        model_step(in_rst);
        act = {digit3, digit2, digit1, digit0, dp, seg_err, frame_valid, anode_err};
        exp = {e_dig[3], e_dig[2], e_dig[1], e_dig[0], e_dp, e_se, e_fv, e_ae};
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL cycle t=%0t got dig=%h dp=%b se=%b fv=%b ae=%b want dig=%h dp=%b se=%b fv=%b ae=%b",
                     $time, act[25:10], act[9:6], act[5:2], act[1], act[0],
                     exp[25:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
        if (frame_valid) fvc++;
        if (anode_err) aec++;
    endtask

    function automatic vec_t mk(logic [3:0] an, logic [7:0] ca, int cyc, logic [15:0] dig,
                                logic [3:0] dpx, logic [3:0] se, int fv, int ae);
        vec_t t;
        t.an = an; t.ca = ca; t.cyc = cyc; t.dig = dig;
        t.dpx = dpx; t.se = se; t.fv = fv; t.ae = ae;
        return t;
    endfunction

    initial begin
        logic [15:0] d;
        tab.push_back(mk(4'hE, 8'hB0,        40,   16'h0003, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hF, 8'hFF,        30,   16'h0003, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hE, cath(1, 0),   1000, 16'h0001, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hD, cath(2, 0),   1000, 16'h0021, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hB, cath(10, 0),  1000, 16'h0A21, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'h7, cath(15, 0),  1000, 16'hFA21, 4'b0000, 4'b0000, 1, 0));
        tab.push_back(mk(4'hE, cath(3, 0),   1000, 16'hFA23, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hB, cath(1, 0),   10,   16'hFA23, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hD, cath(5, 0),   1000, 16'hFA53, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hC, cath(8, 0),   40,   16'hFA53, 4'b0000, 4'b0000, 0, 1));
        tab.push_back(mk(4'hF, 8'hFF,        40,   16'hFA53, 4'b0000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hD, 8'h3C,        40,   16'hFA53, 4'b0010, 4'b0010, 0, 0));
        tab.push_back(mk(4'hB, cath(7, 0),   40,   16'hF753, 4'b0010, 4'b0010, 0, 0));
        tab.push_back(mk(4'h7, cath(0, 1),   40,   16'h0753, 4'b1010, 4'b0010, 1, 0));
        tab.push_back(mk(4'hE, cath(9, 0),   40,   16'h0759, 4'b1010, 4'b0010, 0, 0));
        tab.push_back(mk(4'hD, cath(11, 0),  40,   16'h07B9, 4'b1000, 4'b0000, 0, 0));
        tab.push_back(mk(4'hB, cath(12, 0),  40,   16'h0CB9, 4'b1000, 4'b0000, 0, 0));

        repeat (3) cycle(1'b1);
        reset = 1'b0;

        foreach (tab[i]) begin
            anode = tab[i].an;
            cathodes = tab[i].ca;
            fvc = 0;
            aec = 0;
            repeat (tab[i].cyc) cycle(1'b0);
            d = {digit3, digit2, digit1, digit0};
            vecs++;
            if (d !== tab[i].dig || dp !== tab[i].dpx || seg_err !== tab[i].se ||
                fvc != tab[i].fv || aec != tab[i].ae) begin
                errs++;
                $display("FAIL step%0d got dig=%h dp=%b se=%b fv#=%0d ae#=%0d want dig=%h dp=%b se=%b fv#=%0d ae#=%0d",
                         i, d, dp, seg_err, fvc, aec, tab[i].dig, tab[i].dpx, tab[i].se, tab[i].fv, tab[i].ae);
            end
        end

        // Reset mid-dwell on digit3 after digits 0..2 were captured.
        anode = 4'h7;
        cathodes = cath(13, 0);
        repeat (8) cycle(1'b0);
        reset = 1'b1;
        repeat (3) cycle(1'b1);
        vecs++;
        if ({digit3, digit2, digit1, digit0, dp, seg_err, frame_valid, anode_err} !== 26'd0) begin
            errs++;
            $display("FAIL reset_clear got dig=%h dp=%b se=%b want all zero",
                     {digit3, digit2, digit1, digit0}, dp, seg_err);
        end
        reset = 1'b0;
        fvc = 0;
        repeat (40) cycle(1'b0);
        vecs++;
        if ({digit3, digit2, digit1, digit0} !== 16'hD000 || fvc != 0) begin
            errs++;
            $display("FAIL post_reset got dig=%h fv#=%0d want dig=d000 fv#=0",
                     {digit3, digit2, digit1, digit0}, fvc);
        end

        // Random dwells, checked cycle by cycle against the model.
        for (int r = 0; r < 250; r++) begin
            case ($urandom_range(0, 9))
                0:       anode = 4'hF;
                1:       anode = 4'($urandom_range(0, 15));
                default: anode = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 9) < 7) cathodes = cath($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else cathodes = 8'($urandom);
            repeat ($urandom_range(1, 40)) cycle(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
